// File: rtl/video_pll_pkg.sv
// Shared constants and width helpers for the video PLL stand-in.
// Optional dynamic-ratio feature is enabled by defining VIDEO_PLL_DYN_EN.
package video_pll_pkg;

    localparam int CLKIN_FREQ_MHZ  = 50;

    localparam int DIV0_DEF        = 2;
    localparam int DIV1_DEF        = 4;
    localparam int DIV2_DEF        = 8;
    localparam int DIV3_DEF        = 10;
    localparam int PHASE0_DEF      = 0;
    localparam int PHASE1_DEF      = 0;
    localparam int PHASE2_DEF      = 0;
    localparam int PHASE3_DEF      = 0;
    localparam int LOCK_CYCLES_DEF = 64;

    // Width of runtime divide ratios and of divider counters in the dynamic build.
    localparam int DIV_W = 10;

    typedef logic [DIV_W-1:0] dyn_div_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Bits needed to hold 0..max_div-1.
    function automatic int cnt_width(input int max_div);
        return (max_div > 2) ? $clog2(max_div) : 1;
    endfunction

    // Bits needed to hold 0..cycles-1.
    function automatic int lock_cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/video_pll_if.sv
// Output clock / lock bundle of the video PLL; with VIDEO_PLL_DYN_EN it also
// carries the runtime ratio inputs and the update strobe.
interface video_pll_if;

    logic clkout0;
    logic clkout1;
    logic clkout2;
    logic clkout3;
    logic pll_lock;

`ifdef VIDEO_PLL_DYN_EN
    video_pll_pkg::dyn_div_t dyn_odiv0;
    video_pll_pkg::dyn_div_t dyn_odiv1;
    video_pll_pkg::dyn_div_t dyn_odiv2;
    video_pll_pkg::dyn_div_t dyn_odiv3;
    logic                    dyn_update;

    modport master (
        output clkout0, clkout1, clkout2, clkout3, pll_lock,
        input  dyn_odiv0, dyn_odiv1, dyn_odiv2, dyn_odiv3, dyn_update
    );
    modport slave (
        input  clkout0, clkout1, clkout2, clkout3, pll_lock,
        output dyn_odiv0, dyn_odiv1, dyn_odiv2, dyn_odiv3, dyn_update
    );
`else
    modport master (
        output clkout0, clkout1, clkout2, clkout3, pll_lock
    );
    modport slave (
        input  clkout0, clkout1, clkout2, clkout3, pll_lock
    );
`endif

endinterface

// File: rtl/video_pll_odiv.sv
// One integer clock divider: phase preload on lock, wrap at ratio-1,
// output high while the count is below ratio/2. Ratios below 2 clamp to 2.
module video_pll_odiv
    import video_pll_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int DIV   = 2,
    parameter int PHASE = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           load,
    input  logic           clear,
    input  logic [CNT_W:0] ratio,
    output logic           clk_out
);

    localparam int RW = CNT_W + 1;

    if (PHASE < 0 || PHASE >= DIV) begin : g_bad_phase
        $error("video_pll_odiv: PHASE (%0d) must be in 0..DIV-1 (DIV=%0d)", PHASE, DIV);
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic [RW-1:0]    ratio_c, last, half;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        ratio_c   = (ratio < RW'(2)) ? RW'(2) : ratio;
        last      = ratio_c - RW'(1);
        half      = ratio_c >> 1;
        cnt_d     = cnt_q;
        clk_out_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = CNT_W'(PHASE);
        end else if (en) begin
            clk_out_d = ({1'b0, cnt_q} < half);
            // >= rather than == so a preload beyond a shrunken ratio still wraps
            cnt_d     = ({1'b0, cnt_q} >= last) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign clk_out = clk_out_q;

endmodule

// File: rtl/video_pll_model.sv
// Behavioural video PLL: four divided clocks from clkin1 plus a one-shot lock flag.
// Define VIDEO_PLL_DYN_EN to add runtime ratio reload through dyn_odiv0..3 / dyn_update.
module video_pll_model
    import video_pll_pkg::*;
#(
    parameter int DIV0        = DIV0_DEF,
    parameter int DIV1        = DIV1_DEF,
    parameter int DIV2        = DIV2_DEF,
    parameter int DIV3        = DIV3_DEF,
    parameter int PHASE0      = PHASE0_DEF,
    parameter int PHASE1      = PHASE1_DEF,
    parameter int PHASE2      = PHASE2_DEF,
    parameter int PHASE3      = PHASE3_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
    input  logic      clkin1,
    input  logic      pll_rst_n,
    video_pll_if.master pll_bus
);

    localparam int DIV_P   [4] = '{DIV0, DIV1, DIV2, DIV3};
    localparam int PHASE_P [4] = '{PHASE0, PHASE1, PHASE2, PHASE3};
`ifdef VIDEO_PLL_DYN_EN
    localparam int CNT_W  = DIV_W;
`else
    localparam int CNT_W  = cnt_width(max4(DIV0, DIV1, DIV2, DIV3));
`endif
    localparam int RW     = CNT_W + 1;
    localparam int LOCK_W = lock_cnt_width(LOCK_CYCLES);

    if (LOCK_CYCLES < 1) begin : g_bad_lock
        $error("video_pll_model: LOCK_CYCLES (%0d) must be >= 1", LOCK_CYCLES);
    end

    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              pll_lock_q, pll_lock_d;
    logic              lock_term, load, restart;
    logic [RW-1:0]     ratio [4];
    logic [3:0]        clk_out;

    always_comb begin
`ifdef VIDEO_PLL_DYN_EN
        restart = pll_bus.dyn_update;
`else
        restart = 1'b0;
`endif
        lock_term  = !pll_lock_q && (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1));
        load       = lock_term && !restart;
        lock_cnt_d = lock_cnt_q;
        pll_lock_d = pll_lock_q;
        if (restart) begin
            lock_cnt_d = '0;
            pll_lock_d = 1'b0;
        end else if (lock_term) begin
            pll_lock_d = 1'b1;
        end else if (!pll_lock_q) begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
    end

    always_ff @(posedge clkin1) begin
        if (!pll_rst_n) begin
            lock_cnt_q <= '0;
            pll_lock_q <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            pll_lock_q <= pll_lock_d;
        end
    end

`ifdef VIDEO_PLL_DYN_EN
    dyn_div_t ratio_q [4];
    dyn_div_t ratio_d [4];
    dyn_div_t dyn_in  [4];

    always_comb begin
        dyn_in[0] = pll_bus.dyn_odiv0;
        dyn_in[1] = pll_bus.dyn_odiv1;
        dyn_in[2] = pll_bus.dyn_odiv2;
        dyn_in[3] = pll_bus.dyn_odiv3;
        ratio_d   = ratio_q;
        if (restart) ratio_d = dyn_in;
        for (int i = 0; i < 4; i++) ratio[i] = {1'b0, ratio_q[i]};
    end

    // NOTE: this tiny ratio register file is reset on purpose so a reset restores the parameter ratios.
    always_ff @(posedge clkin1) begin
        if (!pll_rst_n) begin
            for (int i = 0; i < 4; i++) ratio_q[i] <= DIV_W'(DIV_P[i]);
        end else begin
            ratio_q <= ratio_d;
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 4; i++) ratio[i] = RW'(DIV_P[i]);
    end
`endif

    for (genvar i = 0; i < 4; i++) begin : g_odiv
        video_pll_odiv #(
            .CNT_W (CNT_W),
            .DIV   (DIV_P[i]),
            .PHASE (PHASE_P[i])
        ) u_odiv (
            .clk     (clkin1),
            .rst_n   (pll_rst_n),
            .en      (pll_lock_q),
            .load    (load),
            .clear   (restart),
            .ratio   (ratio[i]),
            .clk_out (clk_out[i])
        );
    end

    assign pll_bus.clkout0  = clk_out[0];
    assign pll_bus.clkout1  = clk_out[1];
    assign pll_bus.clkout2  = clk_out[2];
    assign pll_bus.clkout3  = clk_out[3];
    assign pll_bus.pll_lock = pll_lock_q;

endmodule

// File: tb/tb_video_pll_model.sv
// Self-checking bench for video_pll_model: two instances (defaults, and PHASE1=2/DIV3=5)
// compared every cycle against an arithmetic model of lock timing and divider phase.
module tb_video_pll_model;

    localparam int LOCK = 64;
    localparam int PH_A [4] = '{0, 0, 0, 0};
    localparam int PH_B [4] = '{0, 2, 0, 0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    video_pll_if bus_a ();
    video_pll_if bus_b ();

    video_pll_model dut_a (
        .clkin1    (clk),
        .pll_rst_n (rst_n),
        .pll_bus   (bus_a)
    );

    video_pll_model #(
        .DIV3   (5),
        .PHASE1 (2)
    ) dut_b (
        .clkin1    (clk),
        .pll_rst_n (rst_n),
        .pll_bus   (bus_b)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: edges since reset release (or last ratio update) and the active ratios.
    int rel        = 0;
    int div_a  [4] = '{2, 4, 8, 10};
    int div_b  [4] = '{2, 4, 8, 5};

`ifdef VIDEO_PLL_DYN_EN
    int   dyn_div [4] = '{2, 4, 8, 10};
    logic dyn_upd     = 1'b0;

    assign bus_a.dyn_odiv0  = 10'(dyn_div[0]);
    assign bus_a.dyn_odiv1  = 10'(dyn_div[1]);
    assign bus_a.dyn_odiv2  = 10'(dyn_div[2]);
    assign bus_a.dyn_odiv3  = 10'(dyn_div[3]);
    assign bus_a.dyn_update = dyn_upd;
    assign bus_b.dyn_odiv0  = 10'(dyn_div[0]);
    assign bus_b.dyn_odiv1  = 10'(dyn_div[1]);
    assign bus_b.dyn_odiv2  = 10'(dyn_div[2]);
    assign bus_b.dyn_odiv3  = 10'(dyn_div[3]);
    assign bus_b.dyn_update = dyn_upd;

    function automatic int clamp2(input int v);
        return (v < 2) ? 2 : v;
    endfunction
`endif

    always @(posedge clk) begin
        if (!rst_n) begin
            rel   <= 0;
            div_a <= '{2, 4, 8, 10};
            div_b <= '{2, 4, 8, 5};
`ifdef VIDEO_PLL_DYN_EN
        end else if (dyn_upd) begin
            rel <= 0;
            for (int n = 0; n < 4; n++) begin
                div_a[n] <= clamp2(dyn_div[n]);
                div_b[n] <= clamp2(dyn_div[n]);
            end
`endif
        end else begin
            rel <= rel + 1;
        end
    end

    // Lock rises on edge LOCK; edge LOCK+j (j>=1) shows the count that was (phase + j-1) mod div.
    function automatic logic exp_clk(input int phase, input int div, input int r);
        int j;
        j = r - LOCK;
        if (j < 1) return 1'b0;
        return ((phase + j - 1) % div) < (div / 2);
    endfunction

    logic [4:0] obs_a, obs_b;
    assign obs_a = {bus_a.pll_lock, bus_a.clkout3, bus_a.clkout2, bus_a.clkout1, bus_a.clkout0};
    assign obs_b = {bus_b.pll_lock, bus_b.clkout3, bus_b.clkout2, bus_b.clkout1, bus_b.clkout0};

    task automatic step_check(input string tag);
        logic [4:0] obs;
        logic       e;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            obs = (d == 0) ? obs_a : obs_b;
            for (int n = 0; n < 4; n++) begin
                e = (d == 0) ? exp_clk(PH_A[n], div_a[n], rel) : exp_clk(PH_B[n], div_b[n], rel);
                checks++;
                if (obs[n] !== e) begin
                    failures++;
                    $display("FAIL %s dut%0d clkout%0d: got %b expected %b (edge %0d)", tag, d, n, obs[n], e, rel);
                end
            end
            checks++;
            if (obs[4] !== (rel >= LOCK)) begin
                failures++;
                $display("FAIL %s dut%0d pll_lock: got %b expected %b (edge %0d)", tag, d, obs[4], rel >= LOCK, rel);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        step_check("reset");
        checks++;
        if ({obs_a, obs_b} !== 10'b0) begin
            failures++;
            $display("FAIL reset_all_zero: got %b expected 0000000000", {obs_a, obs_b});
        end
    endtask

    task automatic test_lock_timing;
        rst_n = 1'b1;
        for (int i = 1; i <= LOCK + 10; i++) begin
            step_check("lock_timing");
            if (i == LOCK - 1 || i == LOCK) begin
                checks++;
                if (bus_a.pll_lock !== (i == LOCK)) begin
                    failures++;
                    $display("FAIL lock_edge_%0d: got %b expected %b", i, bus_a.pll_lock, i == LOCK);
                end
            end
        end
    endtask

    task automatic test_divider_run;
        int n;
        n = $urandom_range(150, 300);
        repeat (n) step_check("divider_run");
    endtask

    task automatic test_duty;
        int hi_a0, hi_a1, hi_a3, hi_b3;
        hi_a0 = 0; hi_a1 = 0; hi_a3 = 0; hi_b3 = 0;
        repeat (20) begin
            step_check("duty");
            hi_a0 += int'(bus_a.clkout0);
            hi_a1 += int'(bus_a.clkout1);
            hi_a3 += int'(bus_a.clkout3);
            hi_b3 += int'(bus_b.clkout3);
        end
        checks++;
        if (hi_a0 != 10) begin failures++; $display("FAIL duty_clkout0: got %0d high expected 10", hi_a0); end
        checks++;
        if (hi_a1 != 10) begin failures++; $display("FAIL duty_clkout1: got %0d high expected 10", hi_a1); end
        checks++;
        if (hi_a3 != 10) begin failures++; $display("FAIL duty_clkout3: got %0d high expected 10", hi_a3); end
        checks++;
        if (hi_b3 != 8) begin failures++; $display("FAIL duty_div5: got %0d high expected 8", hi_b3); end
    endtask

    task automatic test_mid_reset;
        int extra;
        repeat (3) begin
            repeat ($urandom_range(5, 120)) step_check("pre_reset");
            rst_n = 1'b0;
            step_check("reset_edge");
            checks++;
            if ({obs_a, obs_b} !== 10'b0) begin
                failures++;
                $display("FAIL mid_reset_zero: got %b expected 0000000000", {obs_a, obs_b});
            end
            extra = $urandom_range(0, 1);
            repeat (extra) step_check("reset_hold");
            rst_n = 1'b1;
            repeat (LOCK + 30) step_check("relock");
        end
    endtask

`ifdef VIDEO_PLL_DYN_EN
    task automatic test_dyn;
        dyn_div[0] = 4;
        dyn_div[1] = $urandom_range(4, 9);
        dyn_div[2] = $urandom_range(2, 12);
        dyn_div[3] = $urandom_range(3, 12);
        dyn_upd    = 1'b1;
        step_check("dyn_update");
        dyn_upd    = 1'b0;
        repeat (30) step_check("dyn_unlocked");
        dyn_div[0] = $urandom_range(0, 6);
        dyn_upd    = 1'b1;
        step_check("dyn_restart");
        dyn_upd    = 1'b0;
        repeat (LOCK + 60) step_check("dyn_relock");
    endtask
`endif

    initial begin
        test_reset;
        test_lock_timing;
        test_divider_run;
        test_duty;
        test_mid_reset;
`ifdef VIDEO_PLL_DYN_EN
        test_dyn;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
